// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit with a single outstanding memory request and a small instruction buffer
//   clk         sole clock, all state updates on posedge
//   clr_n       asynchronous active-low reset
//   pc_in       fetch target (word address), sampled when redirect=1
//   redirect    flush the buffer and restart fetching at pc_in
//   halt        level; blocks new fetches, outstanding one completes
//   mem_req/mem_addr/mem_ack              request channel (held until ack)
//   mem_rvalid/mem_rdata                  response channel
//   inst_valid/inst/inst_pc/inst_ready    consumer valid/ready channel
//   busy        request outstanding (REQ or WAIT)
//   fetch_count instructions pushed into the buffer (wraps)
module inst_fetch #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] pc_in,
  input  logic        redirect,
  input  logic        halt,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        busy,
  output logic [31:0] fetch_count
);
  localparam int AW = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} state_t;
  state_t r_state, w_next;
  logic [31:0] r_fetch_addr, r_mem_addr, r_fetch_count;
  logic r_drop;
  logic [31:0] r_buf_inst [BUF_DEPTH];
  logic [31:0] r_buf_pc [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic w_start, w_ack, w_resp, w_push, w_pop, w_inflight;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_state <= IDLE;
    else r_state <= w_next;
  // A redirect empties the buffer this cycle, so it always leaves room for a request.
  always_comb begin
    w_next = r_state;
    w_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_start = !halt && (redirect || r_count < (AW+1)'(BUF_DEPTH));
        w_next = halt ? HALTED : w_start ? REQ : IDLE;
      end
      REQ:    w_next = mem_ack ? WAIT : REQ;
      WAIT:   w_next = mem_rvalid ? (halt ? HALTED : IDLE) : WAIT;
      HALTED: w_next = halt ? HALTED : IDLE;
    endcase
  end
  assign w_inflight = r_state == REQ || r_state == WAIT;
  assign w_ack = r_state == REQ && mem_ack;
  assign w_resp = r_state == WAIT && mem_rvalid;
  assign w_push = w_resp && !r_drop && !redirect;
  assign w_pop = inst_valid && inst_ready && !redirect;
  // With r_drop set, fetch_addr already holds the redirect target and must not advance.
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_fetch_addr <= '0;
      r_mem_addr <= '0;
      r_drop <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_fetch_count <= '0;
    end else begin
      r_fetch_addr <= redirect ? pc_in : (w_ack && !r_drop) ? r_fetch_addr + 32'd1 : r_fetch_addr;
      if (w_start) r_mem_addr <= redirect ? pc_in : r_fetch_addr;
      r_drop <= w_resp ? 1'b0 : (redirect && w_inflight) ? 1'b1 : r_drop;
      r_wr_ptr <= redirect ? '0 : r_wr_ptr + AW'(w_push);
      r_rd_ptr <= redirect ? '0 : r_rd_ptr + AW'(w_pop);
      r_count <= redirect ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_fetch_count <= r_fetch_count + 32'd1;
    end
  always_ff @(posedge clk)
    if (w_push) begin
      r_buf_inst[r_wr_ptr] <= mem_rdata;
      r_buf_pc[r_wr_ptr] <= r_mem_addr;
    end
  assign mem_req = r_state == REQ;
  assign mem_addr = r_mem_addr;
  assign busy = w_inflight;
  assign fetch_count = r_fetch_count;
  assign inst_valid = r_count != '0;
  // Head entry gated so an empty buffer presents zeros (reset values included).
  assign inst = inst_valid ? r_buf_inst[r_rd_ptr] : '0;
  assign inst_pc = inst_valid ? r_buf_pc[r_rd_ptr] : '0;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, instruction buffer depth (power of 2, >=2).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port clr_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pc_in  in  32  word-address fetch target from the PC block, sampled only when redirect=1.
REQ-005 SHALL have port redirect  in  1  flush request; restart fetching at pc_in.
REQ-006 SHALL have port halt  in  1  level, stop-PC seen; blocks new fetches.
REQ-007 SHALL have ports mem_req out 1, mem_addr out 32, mem_ack in 1 (address accepted), mem_rvalid in 1, mem_rdata in 32.
REQ-008 SHALL have ports inst_valid out 1, inst out 32, inst_pc out 32, inst_ready in 1 (consumer side, valid/ready).
REQ-009 SHALL have ports busy out 1 (request outstanding) and fetch_count out 32 (instructions delivered into buffer).

Function
REQ-010 SHALL hold fetch_addr, a word address; all addresses word-granular, low byte bits ignored.
REQ-011 SHALL implement states IDLE, REQ, WAIT, HALTED; at most one memory request outstanding.
REQ-012 IDLE->REQ when halt=0 and (buffer count + outstanding) < BUF_DEPTH; mem_req=1, mem_addr=fetch_addr in REQ.
REQ-013 SHALL keep mem_req and mem_addr stable in REQ until the cycle mem_ack=1; then ->WAIT, fetch_addr <= fetch_addr+1 (32-bit wrap, 0xFFFFFFFF->0).
REQ-014 In WAIT, mem_rvalid=1 SHALL push {mem_rdata, request address} into buffer, increment fetch_count (wraps), and ->IDLE; re-request possible next cycle.
REQ-015 mem_rvalid outside WAIT SHALL be ignored.
REQ-016 inst_valid=1 iff buffer non-empty; inst/inst_pc = head entry; pop on inst_valid&inst_ready.
REQ-017 Response accepted in cycle M into empty buffer SHALL appear as inst_valid=1 in cycle M+1.
REQ-018 Simultaneous push and pop SHALL keep count unchanged, including at full.
REQ-019 redirect=1 SHALL empty the buffer (inst_valid=0 next cycle) and load fetch_addr<=pc_in; flush wins over a same-cycle pop or push.
REQ-020 redirect in IDLE: next cycle REQ with mem_addr=pc_in (subject to halt).
REQ-021 redirect in REQ or WAIT: set drop flag; the outstanding transaction completes per handshake, its response SHALL be discarded (no push, no fetch_count increment), then fetch resumes at pc_in.
REQ-022 halt=1: no new request; an outstanding transaction completes and is pushed; state ->HALTED once nothing outstanding; buffer contents still drain.
REQ-023 HALTED->IDLE when halt=0; redirect while HALTED loads fetch_addr and flushes but stays HALTED.
REQ-024 busy=1 in REQ and WAIT, else 0.
REQ-025 fetch_addr, mem_addr and inst_pc arithmetic SHALL be 32-bit unsigned modulo 2^32.

Reset
REQ-026 clr_n=0 SHALL immediately, without clk, force: state IDLE, fetch_addr 0, drop flag 0, buffer empty, mem_req 0, mem_addr 0, inst_valid 0, inst 0, inst_pc 0, busy 0, fetch_count 0.
REQ-027 After clr_n rises, fetching SHALL start at address 0 without a redirect.
REQ-028 Reset mid-transaction SHALL abandon it; a later mem_rvalid for it is ignored per REQ-015.

Verification
REQ-029 Reset release, memory acks same cycle, rvalid next cycle with rdata=0x1000+addr, inst_ready=1 -> inst_pc 0,1,2,... with inst 0x1000,0x1001,...; fetch_count tracks count.
REQ-030 inst_ready=0 from reset, BUF_DEPTH=2 -> exactly 2 requests (addr 0,1), mem_req then stays 0, inst_pc holds 0; inst_ready=1 -> pops 0,1, request addr 2 issued.
REQ-031 redirect with pc_in=0x40 during WAIT for addr 5 -> addr 5 response dropped, fetch_count unchanged by it, next mem_addr=0x40, first inst_pc after flush =0x40.
REQ-032 halt=1 while in REQ with mem_ack delayed 3 cycles -> mem_addr held 3 cycles, response pushed, HALTED, busy=0, no mem_req; halt=0 -> next sequential address requested.
REQ-033 redirect to 0xFFFFFFFF -> fetches 0xFFFFFFFF then 0x00000000, inst_pc matching.
REQ-034 clr_n=0 asynchronously during WAIT -> all outputs at REQ-026 values before next clk edge; stale mem_rvalid ignored; fetch restarts at 0.
